// File: rtl/conv_out_collector_pkg.sv
//------------------------------------------------------------------------------
// Package : conv_pkg
// Purpose : Shared constants and helpers for the conv output collector.
//           Holds the default word width, the default beat counts and a
//           clog2 variant that never returns 0, so a counter for a single
//           beat still has a legal 1-bit width.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

  localparam int WORD_WIDTH_DEFAULT = 8;
  localparam int FILTERS_DEFAULT    = 8;
  localparam int IN_WORDS_DEFAULT   = 8;
  localparam int OUT_WORDS_DEFAULT  = 1;

  // Beat counts for the default configuration.
  localparam int BEATS_IN  = FILTERS_DEFAULT / IN_WORDS_DEFAULT;
  localparam int BEATS_OUT = FILTERS_DEFAULT / OUT_WORDS_DEFAULT;

  // Counter width for a counter with n states; at least 1 bit.
  function automatic int safe_clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_out_collector_bank.sv
//------------------------------------------------------------------------------
// Module  : collector_bank
// Purpose : One pixel bank: FILTERS words of WORD_WIDTH bits. Written one
//           input beat (IN_WORDS words) at a time, read one output beat
//           (OUT_WORDS words) at a time through a combinational mux.
//           Storage is deliberately not reset.
// Ports   : i_aclk   - clock
//           i_we     - write the beat at index i_wbeat
//           i_wbeat  - input beat index (word offset i_wbeat*IN_WORDS)
//           i_wdata  - input beat data
//           i_rbeat  - output beat index (word offset i_rbeat*OUT_WORDS)
//           o_rdata  - output beat data
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module collector_bank
  import conv_pkg::*;
#(
  parameter int FILTERS    = FILTERS_DEFAULT,
  parameter int IN_WORDS   = IN_WORDS_DEFAULT,
  parameter int OUT_WORDS  = OUT_WORDS_DEFAULT,
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter int WBEAT_W    = safe_clog2(FILTERS / IN_WORDS),
  parameter int RBEAT_W    = safe_clog2(FILTERS / OUT_WORDS)
) (
  input  logic                            i_aclk,
  input  logic                            i_we,
  input  logic [WBEAT_W-1:0]              i_wbeat,
  input  logic [IN_WORDS*WORD_WIDTH-1:0]  i_wdata,
  input  logic [RBEAT_W-1:0]              i_rbeat,
  output logic [OUT_WORDS*WORD_WIDTH-1:0] o_rdata
);

  localparam int C_BEATS_IN  = FILTERS / IN_WORDS;
  localparam int C_BEATS_OUT = FILTERS / OUT_WORDS;
  localparam int C_IN_BITS   = IN_WORDS * WORD_WIDTH;
  localparam int C_OUT_BITS  = OUT_WORDS * WORD_WIDTH;

  // Flat word store: filter f lives at bits [f*WORD_WIDTH +: WORD_WIDTH].
  logic [FILTERS*WORD_WIDTH-1:0] r_mem;

  always_ff @(posedge i_aclk) begin
    if (i_we) begin
      for (int b = 0; b < C_BEATS_IN; b++) begin
        if (i_wbeat == WBEAT_W'(b))
          r_mem[b*C_IN_BITS +: C_IN_BITS] <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int b = 0; b < C_BEATS_OUT; b++) begin
      if (i_rbeat == RBEAT_W'(b))
        o_rdata = r_mem[b*C_OUT_BITS +: C_OUT_BITS];
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_out_collector.sv
//------------------------------------------------------------------------------
// Module  : conv_out_collector
// Purpose : AXI4-stream sink for the Conv2D3x3 output. Collects FILTERS words
//           per pixel (IN_WORDS per beat) into two ping-pong banks and
//           re-emits each pixel as OUT_WORDS-wide beats. tlast marks the
//           last beat of the last pixel of each output feature map, and
//           o_frame_done pulses for one cycle after that beat is taken.
// Config  : CONV_OUT_RELU_EN - when defined, output words with the sign bit
//           set are driven as zero (stored data is untouched).
// Ports   : i_aclk, i_aresetn (async, active low)
//           i_in_tvalid / o_in_tready / i_in_tdata      - input stream
//           o_out_tvalid / i_out_tready / o_out_tdata   - output stream
//           o_out_tlast   - last beat of the feature map
//           o_frame_done  - one-cycle pulse after the tlast handshake
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_out_collector
  import conv_pkg::*;
#(
  parameter int IMG_HEIGHT = 4,
  parameter int IMG_WIDTH  = 4,
  parameter int FILTERS    = FILTERS_DEFAULT,
  parameter int IN_WORDS   = IN_WORDS_DEFAULT,
  parameter int OUT_WORDS  = OUT_WORDS_DEFAULT,
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic                            i_aclk,
  input  logic                            i_aresetn,
  input  logic                            i_in_tvalid,
  output logic                            o_in_tready,
  input  logic [IN_WORDS*WORD_WIDTH-1:0]  i_in_tdata,
  output logic                            o_out_tvalid,
  input  logic                            i_out_tready,
  output logic [OUT_WORDS*WORD_WIDTH-1:0] o_out_tdata,
  output logic                            o_out_tlast,
  output logic                            o_frame_done
);

  localparam int C_BEATS_IN  = FILTERS / IN_WORDS;
  localparam int C_BEATS_OUT = FILTERS / OUT_WORDS;
  localparam int C_PIXELS    = (IMG_HEIGHT - 2) * (IMG_WIDTH - 2);
  localparam int WI_W        = safe_clog2(C_BEATS_IN);
  localparam int RI_W        = safe_clog2(C_BEATS_OUT);
  localparam int PC_W        = safe_clog2(C_PIXELS);
  localparam int C_OUT_BITS  = OUT_WORDS * WORD_WIDTH;

  localparam logic [WI_W-1:0] C_WI_LAST = WI_W'(C_BEATS_IN - 1);
  localparam logic [RI_W-1:0] C_RI_LAST = RI_W'(C_BEATS_OUT - 1);
  localparam logic [PC_W-1:0] C_PC_LAST = PC_W'(C_PIXELS - 1);

  logic [1:0]      r_full;
  logic            r_wb;
  logic            r_rb;
  logic [WI_W-1:0] r_wi;
  logic [RI_W-1:0] r_ri;
  logic [PC_W-1:0] r_pc;
  logic            r_frame_done;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_wi_last;
  logic            w_ri_last;
  logic            w_pc_last;
  logic [1:0]      w_we;
  logic [C_OUT_BITS-1:0] w_rdata [2];

  // A bank only accepts writes while empty, so the write bank can never be
  // the one being released in the same cycle.
  assign o_in_tready  = ~r_full[r_wb];
  assign o_out_tvalid = r_full[r_rb];
  assign w_in_fire    = i_in_tvalid & o_in_tready;
  assign w_out_fire   = o_out_tvalid & i_out_tready;
  assign w_wi_last    = (r_wi == C_WI_LAST);
  assign w_ri_last    = (r_ri == C_RI_LAST);
  assign w_pc_last    = (r_pc == C_PC_LAST);
  assign o_out_tlast  = o_out_tvalid & w_ri_last & w_pc_last;
  assign o_frame_done = r_frame_done;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_we[b] = w_in_fire & (r_wb == 1'(b));

    collector_bank #(
      .FILTERS    (FILTERS),
      .IN_WORDS   (IN_WORDS),
      .OUT_WORDS  (OUT_WORDS),
      .WORD_WIDTH (WORD_WIDTH),
      .WBEAT_W    (WI_W),
      .RBEAT_W    (RI_W)
    ) u_bank (
      .i_aclk  (i_aclk),
      .i_we    (w_we[b]),
      .i_wbeat (r_wi),
      .i_wdata (i_in_tdata),
      .i_rbeat (r_ri),
      .o_rdata (w_rdata[b])
    );
  end

  for (genvar j = 0; j < OUT_WORDS; j++) begin : g_lane
`ifdef CONV_OUT_RELU_EN
    // Clamp negative words at the output only.
    assign o_out_tdata[j*WORD_WIDTH +: WORD_WIDTH] =
      w_rdata[r_rb][j*WORD_WIDTH + WORD_WIDTH - 1] ? '0
                                                   : w_rdata[r_rb][j*WORD_WIDTH +: WORD_WIDTH];
`else
    assign o_out_tdata[j*WORD_WIDTH +: WORD_WIDTH] = w_rdata[r_rb][j*WORD_WIDTH +: WORD_WIDTH];
`endif
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_full       <= 2'b00;
      r_wb         <= 1'b0;
      r_rb         <= 1'b0;
      r_wi         <= '0;
      r_ri         <= '0;
      r_pc         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_in_fire) begin
        if (w_wi_last) begin
          r_full[r_wb] <= 1'b1;
          r_wb         <= ~r_wb;
          r_wi         <= '0;
        end else begin
          r_wi <= r_wi + 1'b1;
        end
      end

      if (w_out_fire) begin
        if (w_ri_last) begin
          r_full[r_rb] <= 1'b0;
          r_rb         <= ~r_rb;
          r_ri         <= '0;
          if (w_pc_last) begin
            r_pc         <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end else begin
          r_ri <= r_ri + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
